fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Y86-64 SEQ fetch stage: takes the current pc and reads instruction bytes over a byte-wide imem port (req/ack).
// - Assembles one instruction and emits icode, ifun, rA, rB, valC, valP and stat to decode/execute.
// - Its valP and valC feed the PC-update stage; its pc input is that stage's registered pc.
// PARAMETERS
// - WORD_W   64  data/address width (matches `WORD)
// - MAX_LEN  10  longest instruction in bytes; sizes the byte counter (4 bits)
// PORTS
// - clk        in   1       rising-edge clock (single clock domain)
// - rst        in   1       synchronous, active-high reset
// - start      in   1       one-cycle pulse: fetch the instruction at pc; honoured only in IDLE
// - pc         in   WORD_W  instruction address; sampled on the cycle start is honoured
// - mem_req    out  1       byte read request
// - mem_addr   out  WORD_W  byte address = pc_q + idx, mod 2^WORD_W
// - mem_ack    in   1       read complete; mem_rdata/mem_err valid this cycle
// - mem_rdata  in   8       read byte
// - mem_err    in   1       address fault; sampled only with mem_ack
// - out_valid  out  1       decoded instruction is held on the outputs
// - out_ready  in   1       consumer accepts the instruction
// - icode      out  4       byte0[7:4]
// - ifun       out  4       byte0[3:0]
// - rA, rB     out  4 each  byte1[7:4] / byte1[3:0]; 4'hF if the instruction has no register byte
// - valC       out  WORD_W  little-endian constant; 0 if the instruction has none
// - valP       out  WORD_W  pc_q + len, mod 2^WORD_W
// - stat       out  2       00 AOK, 01 HLT, 10 ADR, 11 INS
// BEHAVIOUR
// - Reset: state=IDLE. mem_req=0, mem_addr=0, out_valid=0, icode=ifun=0, rA=rB=4'hF, valC=valP=0, stat=00.
// - FSM states: IDLE, REQ, DONE.
// - IDLE: start=1 -> latch pc_q=pc, idx=0, go to REQ. start is ignored in REQ/DONE (no queueing).
// - REQ: mem_req=1, mem_addr=pc_q+idx. Req and addr are held constant until the cycle mem_ack=1.
// - On ack with mem_err=1: stat=ADR (10); valP=pc_q+idx; go to DONE; other fields keep the bytes captured so far.
// - On ack of byte 0: set icode/ifun and len from icode:
//   - 0, 1, 9 -> 1 byte
//   - 2, 6, A, B -> 2 bytes
//   - 3, 4, 5 -> 10 bytes
//   - 7, 8 -> 9 bytes
//   - icode > B: stat=INS, len=1, go to DONE
// - valC byte placement:
//   - icode 3/4/5: byte k (2..9) -> valC[8(k-2)+:8]
//   - icode 7/8: byte k (1..8) -> valC[8(k-1)+:8]
// - After an ack, if idx==len-1 go to DONE; else idx++ and stay in REQ. mem_req may stay high back-to-back.
// - DONE:
//   - out_valid=1; all outputs stable while out_valid && !out_ready.
//   - out_ready=1 -> IDLE next cycle; out_valid drops and outputs hold their last values.
//   - stat=HLT (01) for icode 0 with no fault; otherwise AOK unless ADR or INS was set.
// - Latency with zero-wait memory (ack in the same cycle as req): start at cycle t -> out_valid at t+1+len.
// - Each wait cycle (req=1, ack=0) adds exactly one cycle.
// - mem_ack while mem_req=0 is ignored.
// - Per-fetch clear: a new fetch clears valC to 0, rA/rB to F and stat to AOK at latch time.
// - rst in any state (including mid-fetch with req pending): next cycle IDLE with reset values; mem_req drops immediately.
// - Address wrap: pc_q=2^64-2, len 10 -> addresses wrap through 0; valP=8.
// TESTING
// - Zero-wait, mem bytes @0x100 = 30 F3 0A 00 00 00 00 00 00 00 (irmovq $10,%rbx) -> out_valid at t+11;
//   icode=3 ifun=0 rA=F rB=3 valC=0xA valP=0x10A stat=00.
// - Zero-wait, @0x40 = 80 00 02 00 00 00 00 00 00 (call 0x200) -> valC=0x200 valP=0x49 rA=rB=F, valid at t+10.
// - Byte 0 = 0xC5 at pc=0x20 -> one mem read only; stat=11 valP=0x21.
//   Next, byte 0 = 0x00 at pc=0 -> stat=01 valP=1.
// - Fetch 60 12 (addq) with 2 wait cycles per byte; hold out_ready=0 for 3 cycles ->
//   mem_addr stable while waiting; valid at t+7; icode=6 ifun=0 rA=1 rB=2 held until ready.
// - mem_err on byte 4 of an irmovq @0x1000 -> stat=10, valP=0x1004, no further req.
//   Separately, rst mid-fetch -> mem_req=0 next cycle, out_valid=0.
// - Wrap: pc=0xFFFF_FFFF_FFFF_FFFE, irmovq -> addresses ...FE, ...FF, 0..7; valP=8.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Y86-64 SEQ fetch stage; reads one instruction a byte at a
//               time over a req/ack port and presents the decoded fields.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int WORD_W  = 64,
    parameter int MAX_LEN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] pc,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [WORD_W-1:0] valC,
    output logic [WORD_W-1:0] valP,
    output logic [1:0]        stat
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] c_STAT_AOK = 2'b00;
    localparam logic [1:0] c_STAT_HLT = 2'b01;
    localparam logic [1:0] c_STAT_ADR = 2'b10;
    localparam logic [1:0] c_STAT_INS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] valc_q, valc_d;
    logic [WORD_W-1:0] valp_q, valp_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [3:0]        icode_q, icode_d;
    logic [3:0]        ifun_q, ifun_d;
    logic [3:0]        ra_q, ra_d;
    logic [3:0]        rb_q, rb_d;
    logic [1:0]        stat_q, stat_d;

    logic [CNT_W-1:0]  w_len;
    logic              w_valc_en;
    logic [CNT_W-1:0]  w_valc_pos;

    function automatic logic [CNT_W-1:0] insn_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       insn_len = CNT_W'(1);
            4'h2, 4'h6, 4'hA, 4'hB: insn_len = CNT_W'(2);
            4'h3, 4'h4, 4'h5:       insn_len = CNT_W'(10);
            4'h7, 4'h8:             insn_len = CNT_W'(9);
            default:                insn_len = CNT_W'(1);
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] ic);
        has_regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    endfunction

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valc_d     = valc_q;
        valp_d     = valp_q;
        idx_d      = idx_q;
        len_d      = len_q;
        icode_d    = icode_q;
        ifun_d     = ifun_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        stat_d     = stat_q;
        w_len      = len_q;
        w_valc_en  = 1'b0;
        w_valc_pos = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = pc;
                    idx_d   = '0;
                    valc_d  = '0;
                    ra_d    = 4'hF;
                    rb_d    = 4'hF;
                    stat_d  = c_STAT_AOK;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (mem_err) begin
                        stat_d  = c_STAT_ADR;
                        valp_d  = pc_q + WORD_W'(idx_q);
                        state_d = ST_DONE;
                    end else begin
                        if (idx_q == '0) begin
                            icode_d = mem_rdata[7:4];
                            ifun_d  = mem_rdata[3:0];
                            w_len   = insn_len(mem_rdata[7:4]);
                            len_d   = w_len;
                            if (mem_rdata[7:4] > 4'hB) begin
                                stat_d = c_STAT_INS;
                            end else if (mem_rdata[7:4] == 4'h0) begin
                                stat_d = c_STAT_HLT;
                            end
                        end else begin
                            if (idx_q == CNT_W'(1) && has_regs(icode_q)) begin
                                ra_d = mem_rdata[7:4];
                                rb_d = mem_rdata[3:0];
                            end
                            // constant starts after the register byte when one is present
                            if (icode_q inside {4'h3, 4'h4, 4'h5} && idx_q >= CNT_W'(2)) begin
                                w_valc_en  = 1'b1;
                                w_valc_pos = idx_q - CNT_W'(2);
                            end else if (icode_q inside {4'h7, 4'h8}) begin
                                w_valc_en  = 1'b1;
                                w_valc_pos = idx_q - CNT_W'(1);
                            end
                            for (int k = 0; k < WORD_W / 8; k++) begin
                                if (w_valc_en && w_valc_pos == CNT_W'(k)) begin
                                    valc_d[8*k +: 8] = mem_rdata;
                                end
                            end
                        end
                        if (idx_q == w_len - CNT_W'(1)) begin
                            valp_d  = pc_q + WORD_W'(w_len);
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            valc_q  <= '0;
            valp_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            stat_q  <= c_STAT_AOK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            stat_q  <= stat_d;
        end
    end

    // reset withdraws a pending request in the same cycle it is asserted
    assign mem_req   = (state_q == ST_REQ) && !rst;
    assign mem_addr  = pc_q + WORD_W'(idx_q);
    assign out_valid = (state_q == ST_DONE);
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign stat      = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomised scoreboard bench for fetch_unit with a memory
//               responder and an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [1:0]  stat;
        int          nreads;
        int          stall;
        int          start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, mem_req, mem_ack, mem_err, out_valid, out_ready;
    logic [63:0] pc, mem_addr, valc, valp;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, ra, rb;
    logic [1:0]  stat;

    fetch_unit #(.WORD_W(64), .MAX_LEN(10)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(ra), .rB(rb),
        .valC(valc), .valP(valp), .stat(stat)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rd_count = 0;
    int          wait_count = 0;
    int          wait_lo  = 0;
    int          wait_hi  = 0;
    logic [63:0] cur_pc   = 64'd0;
    logic [63:0] err_addr = 64'd0;
    logic        err_en   = 1'b0;
    logic        txn_done = 1'b0;
    logic [3:0]  model_icode = 4'h0;
    logic [3:0]  model_ifun  = 4'h0;
    logic [7:0]  mem [logic [63:0]];
    exp_t        sb_q [$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [159:0] pack_dut();
        return {14'd0, icode, ifun, ra, rb, valc, valp, stat};
    endfunction

    function automatic logic [159:0] pack_exp(input exp_t e);
        return {14'd0, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat};
    endfunction

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic load(input logic [63:0] a, input logic [79:0] bytes, input int n);
        for (int k = 0; k < n; k++) mem[a + 64'(k)] = bytes[79 - 8*k -: 8];
    endtask

    function automatic exp_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] r_a, input logic [3:0] r_b,
                                input logic [63:0] vc, input logic [63:0] vp,
                                input logic [1:0] st, input int nr, input int stl);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = r_a; e.rb = r_b;
        e.valc = vc; e.valp = vp; e.stat = st; e.nreads = nr; e.stall = stl;
        e.start_cyc = 0;
        return e;
    endfunction

    // Instruction-level reference: length table, fault position, field extraction.
    function automatic exp_t model(input logic [63:0] a, input logic eo, input logic [63:0] ea);
        exp_t       e;
        logic [7:0] b [10];
        int         len, nread, off;
        logic [3:0] ic;
        for (int k = 0; k < 10; k++) b[k] = mem_byte(a + 64'(k));
        ic = b[0][7:4];
        case (ic)
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h3, 4'h4, 4'h5:       len = 10;
            4'h7, 4'h8:             len = 9;
            default:                len = 1;
        endcase
        nread = len;
        for (int k = len - 1; k >= 0; k--) if (eo && (a + 64'(k)) == ea) nread = k;
        e = mk(model_icode, model_ifun, 4'hF, 4'hF, 64'd0, a + 64'(len),
               (ic > 4'hB) ? 2'b11 : (ic == 4'h0) ? 2'b01 : 2'b00, len, 0);
        if (nread >= 1) begin
            e.icode = ic;
            e.ifun  = b[0][3:0];
        end
        if (nread >= 2 && ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
            e.ra = b[1][7:4];
            e.rb = b[1][3:0];
        end
        off = (ic inside {4'h3, 4'h4, 4'h5}) ? 2 : (ic inside {4'h7, 4'h8}) ? 1 : 0;
        if (off != 0)
            for (int j = 0; j < 8; j++)
                if (off + j < nread) e.valc = e.valc | (64'(b[off + j]) << (8 * j));
        if (nread < len) begin
            e.stat   = 2'b10;
            e.valp   = a + 64'(nread);
            e.nreads = nread + 1;
        end
        return e;
    endfunction

    task automatic issue(input logic [63:0] a, input exp_t e_in, input int wlo, input int whi);
        exp_t e;
        int   guard;
        e = e_in;
        @(negedge clk);
        wait_lo = wlo; wait_hi = whi; cur_pc = a;
        rd_count = 0; wait_count = 0; txn_done = 1'b0;
        start = 1'b1; pc = a;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        model_icode = e.icode;
        model_ifun  = e.ifun;
        guard = 0;
        do begin
            @(negedge clk);
            if (!txn_done) begin
                // stray starts while busy must be ignored
                start = ($urandom_range(0, 3) == 0);
                pc    = {$urandom, $urandom};
                guard++;
                if (guard > 400) begin
                    n_checks++; n_fail++;
                    $display("FAIL fetch_timeout: no accepted output after %0d cycles, required one", guard);
                    finish_test();
                end
            end
        end while (!txn_done);
        start = 1'b0;
        txn_done = 1'b0;
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctl"}, {94'd0, mem_req, out_valid, mem_addr}, 160'd0);
        check({name, "_fields"}, pack_dut(),
              {14'd0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'b00});
    endtask

    // Memory responder: random wait states, fault injection, address tracking.
    initial begin
        logic [63:0] req_addr;
        logic        busy;
        int          wleft;
        mem_ack = 1'b0; mem_rdata = 8'd0; mem_err = 1'b0;
        busy = 1'b0; wleft = 0; req_addr = 64'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    req_addr = mem_addr;
                    wleft = int'($urandom_range(wait_hi, wait_lo));
                    check("mem_addr_seq", {96'd0, mem_addr}, {96'd0, cur_pc + 64'(rd_count)});
                end else begin
                    check("mem_addr_held", {96'd0, mem_addr}, {96'd0, req_addr});
                end
                if (wleft == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_byte(req_addr);
                    mem_err   = err_en && (req_addr == err_addr);
                    busy      = 1'b0;
                    rd_count++;
                end else begin
                    wleft--;
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    mem_err   = 1'($urandom);
                    wait_count++;
                end
            end else begin
                mem_ack   = 1'($urandom);
                mem_rdata = 8'($urandom);
                mem_err   = 1'($urandom);
                busy      = 1'b0;
            end
        end
    end

    // Monitor: compares presented instructions against the scoreboard.
    initial begin
        exp_t e, last;
        logic seen, drop;
        int   stall;
        out_ready = 1'b0; seen = 1'b0; drop = 1'b0; stall = 0;
        last = mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'b00, 0, 0);
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0; drop = 1'b0; out_ready = 1'b0;
            end else begin
                if (drop) begin
                    check("valid_drops", {159'd0, out_valid}, 160'd0);
                    check("hold_after_accept", pack_dut(), pack_exp(last));
                    drop = 1'b0;
                end
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_valid", {159'd0, out_valid}, 160'd0);
                        out_ready = 1'b1;
                    end else begin
                        e = sb_q[0];
                        if (!seen) begin
                            seen  = 1'b1;
                            stall = e.stall;
                            check("latency", 160'(cyc - e.start_cyc), 160'(1 + e.nreads + wait_count));
                            check("mem_reads", 160'(rd_count), 160'(e.nreads));
                        end
                        check("fields", pack_dut(), pack_exp(e));
                        if (stall > 0) begin
                            out_ready = 1'b0;
                            stall--;
                        end else begin
                            out_ready = 1'b1;
                        end
                        if (out_ready) begin
                            void'(sb_q.pop_front());
                            last = e; drop = 1'b1; seen = 1'b0; txn_done = 1'b1;
                        end
                    end
                end else begin
                    out_ready = 1'($urandom);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; pc = 64'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        load(64'h100, 80'h30F30A00000000000000, 10);
        issue(64'h100, mk(4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'h10A, 2'b00, 10, 0), 0, 0);

        load(64'h40, 80'h80000200000000000000, 9);
        issue(64'h40, mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h49, 2'b00, 9, 0), 0, 0);

        load(64'h20, 80'hC5000000000000000000, 1);
        issue(64'h20, mk(4'hC, 4'h5, 4'hF, 4'hF, 64'h0, 64'h21, 2'b11, 1, 0), 0, 0);

        load(64'h0, 80'h00000000000000000000, 1);
        issue(64'h0, mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 2'b01, 1, 0), 0, 0);

        load(64'h300, 80'h60120000000000000000, 2);
        issue(64'h300, mk(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h302, 2'b00, 2, 3), 2, 2);

        load(64'h1000, 80'h30F30A00000000000000, 10);
        err_en = 1'b1; err_addr = 64'h1004;
        issue(64'h1000, mk(4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'h1004, 2'b10, 5, 0), 0, 1);
        err_en = 1'b0;

        load(64'hFFFF_FFFF_FFFF_FFFE, 80'h30F31122334455667788, 10);
        issue(64'hFFFF_FFFF_FFFF_FFFE,
              mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h8877665544332211, 64'h8, 2'b00, 10, 0), 0, 0);

        // reset while a request is outstanding
        load(64'h100, 80'h30F30A00000000000000, 10);
        @(negedge clk);
        wait_lo = 1; wait_hi = 1; cur_pc = 64'h100; rd_count = 0;
        start = 1'b1; pc = 64'h100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("req_before_rst", {159'd0, mem_req}, 160'd1);
        rst = 1'b1;
        #1;
        check("req_drops_in_rst", {159'd0, mem_req}, 160'd0);
        @(negedge clk);
        check_reset("mid_fetch_rst");
        @(negedge clk);
        rst = 1'b0;
        model_icode = 4'h0;
        model_ifun  = 4'h0;

        for (int i = 0; i < 60; i++) begin
            logic [63:0] a, ea;
            logic        eo;
            exp_t        e;
            a = ($urandom_range(0, 3) == 0) ? (64'd0 - 64'($urandom_range(1, 12)))
                                            : {$urandom, $urandom};
            for (int k = 0; k < 10; k++) mem[a + 64'(k)] = 8'($urandom);
            eo = ($urandom_range(0, 7) == 0);
            ea = a + 64'($urandom_range(0, 9));
            err_en = eo; err_addr = ea;
            e = model(a, eo, ea);
            e.stall = int'($urandom_range(0, 2));
            issue(a, e, 0, 2);
        end
        err_en = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 160'(sb_q.size()), 160'd0);
        finish_test();
    end

endmodule
`default_nettype wire
